// File: rtl/rr_arb_7seg.sv
// rr_arb_7seg -- 8-way round-robin arbiter with a seven-segment readout of
// the current grant.
//
// Optional feature (macro ARB_TIMEOUT_EN): when defined, a grant held for
// TIMEOUT consecutive GRANT cycles is forcibly released, and tmo pulses
// high for one cycle. When undefined, a grant is held for as long as its
// request stays high, and tmo stays 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req[7:0]   in   request lines, bit i = requester i, level-held
//   grant[7:0] out  registered one-hot grant, zero when idle
//   gnt_idx    out  registered index of the current/last grant
//   gnt_valid  out  registered, high while grant is non-zero
//   hex[7:0]   out  registered active-low {a,b,c,d,e,f,g,dp}; shows
//                   gnt_idx with dp lit in GRANT, blank (8'hFF) in IDLE
//   tmo        out  registered one-cycle pulse on forced release
module rr_arb_7seg #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic [7:0] hex,
  output logic       tmo
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // Value of cnt during the last permitted GRANT cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [7:0] hex_q, hex_d;
  logic       tmo_q, tmo_d;

  logic       start;
  logic       hold_lost;
  logic       tmo_hit;
  logic [2:0] win_idx;

  // First set request bit at or after p, wrapping 7 -> 0. The search runs
  // from the farthest offset back to the nearest, so the nearest set bit
  // is the final assignment.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = p;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Active-low segment pattern for a digit, dp off.
  function automatic logic [7:0] seg_digit(input logic [2:0] d);
    case (d)
      3'd0:    seg_digit = 8'h03;
      3'd1:    seg_digit = 8'h9F;
      3'd2:    seg_digit = 8'h25;
      3'd3:    seg_digit = 8'h0D;
      3'd4:    seg_digit = 8'h99;
      3'd5:    seg_digit = 8'h49;
      3'd6:    seg_digit = 8'h41;
      default: seg_digit = 8'h1F;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      cnt_q       <= 8'd0;
      grant_q     <= 8'h00;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      hex_q       <= 8'hFF;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      hex_q       <= hex_d;
      tmo_q       <= tmo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    start     = (state_q == IDLE) && (req != 8'h00);
    hold_lost = !req[gnt_idx_q];
    // A dropped request takes precedence, so tmo only marks a release the
    // holder did not ask for.
    tmo_hit   = TMO_EN && (state_q == GRANT) && !hold_lost && (cnt_q == TMO_LAST);
    state_d   = state_q;
    case (state_q)
      IDLE:    if (start) state_d = GRANT;
      GRANT:   if (hold_lost || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    win_idx     = rr_pick(req, ptr_q);
    gnt_idx_d   = start ? win_idx : gnt_idx_q;
    ptr_d       = start ? win_idx + 3'd1 : ptr_q;
    cnt_d       = cnt_q;
    if (start) begin
      cnt_d = 8'd0;
    end else if ((state_q == GRANT) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
    gnt_valid_d = (state_d == GRANT);
    grant_d     = gnt_valid_d ? (8'h01 << gnt_idx_d) : 8'h00;
    hex_d       = gnt_valid_d ? (seg_digit(gnt_idx_d) & 8'hFE) : 8'hFF;
    tmo_d       = tmo_hit;
  end

  assign grant     = grant_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign hex       = hex_q;
  assign tmo       = tmo_q;

endmodule

// File: tb/tb_rr_arb_7seg.sv
// Directed testbench for rr_arb_7seg (TIMEOUT = 4). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point.
module tb_rr_arb_7seg;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [7:0] hex;
  logic       tmo;

  int checks   = 0;
  int failures = 0;

  rr_arb_7seg #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .hex       (hex),
    .tmo       (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                           input logic v, input logic [7:0] h, input logic t);
    check({tag, ".grant"},     32'(grant),     32'(g));
    check({tag, ".gnt_idx"},   32'(gnt_idx),   32'(idx));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
    check({tag, ".hex"},       32'(hex),       32'(h));
    check({tag, ".tmo"},       32'(tmo),       32'(t));
  endtask

  // Active-low digit, dp lit.
  function automatic logic [7:0] dig_dp(input int d);
    logic [7:0] tbl [8];
    tbl = '{8'h02, 8'h9E, 8'h24, 8'h0C, 8'h98, 8'h48, 8'h40, 8'h1E};
    return tbl[d];
  endfunction

  logic [7:0] exp_g5, exp_g6, exp_h5, exp_h6;
  logic       exp_v5, exp_t5;

  initial begin
`ifdef ARB_TIMEOUT_EN
    exp_g5 = 8'h00; exp_v5 = 1'b0; exp_h5 = 8'hFF; exp_t5 = 1'b1;
`else
    exp_g5 = 8'h08; exp_v5 = 1'b1; exp_h5 = 8'h0C; exp_t5 = 1'b0;
`endif
    exp_g6 = 8'h08; exp_h6 = 8'h0C;

    // Reset with no requests.
    rst_n = 1'b0;
    req   = 8'h00;
    #12;
    check_out("rst", 8'h00, 3'd0, 1'b0, 8'hFF, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check_out("idle0", 8'h00, 3'd0, 1'b0, 8'hFF, 1'b0);

    // Request glitch between edges is never sampled.
    req = 8'h01;
    #3;
    req = 8'h00;
    step();
    check_out("glitch", 8'h00, 3'd0, 1'b0, 8'hFF, 1'b0);

    // req 81 from reset: 0 first, then 7 after a dead cycle.
    req = 8'h81;
    step();
    check_out("g0", 8'h01, 3'd0, 1'b1, 8'h02, 1'b0);
    step();
    check("g0_hold", 32'(grant), 32'h01);
    req = 8'h80;
    step();
    check_out("dead0", 8'h00, 3'd0, 1'b0, 8'hFF, 1'b0);
    step();
    check_out("g7", 8'h80, 3'd7, 1'b1, 8'h1E, 1'b0);
    req = 8'h00;
    step();
    check_out("idle7", 8'h00, 3'd7, 1'b0, 8'hFF, 1'b0);

    // All requesting: rotation 0..7,0 with a dead cycle between grants.
    for (int k = 0; k <= 8; k++) begin
      req = 8'hFF;
      step();
      check_out($sformatf("rot%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1,
                dig_dp(k % 8), 1'b0);
      step();
      check($sformatf("rot%0d_hold", k), 32'(grant), 32'(8'h01 << (k % 8)));
      req = 8'hFF & ~(8'h01 << (k % 8));
      step();
      check($sformatf("rot%0d_dead", k), 32'(grant), 32'h00);
    end
    req = 8'h00;
    step();

    // Async reset mid-grant, then pointer restarts at 0.
    req = 8'h20;
    step();
    check_out("g5", 8'h20, 3'd5, 1'b1, 8'h48, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("arst", 8'h00, 3'd0, 1'b0, 8'hFF, 1'b0);
    req   = 8'h24;
    rst_n = 1'b1;
    step();
    check_out("post_rst", 8'h04, 3'd2, 1'b1, 8'h24, 1'b0);

    // Hold / forced release with TIMEOUT = 4.
    req = 8'h00;
    step();
    req = 8'h08;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_out($sformatf("to_c%0d", c), 8'h08, 3'd3, 1'b1, 8'h0C, 1'b0);
    end
    step();
    check_out("to_rel", exp_g5, 3'd3, exp_v5, exp_h5, exp_t5);
    step();
    check_out("to_again", exp_g6, 3'd3, 1'b1, exp_h6, 1'b0);
    req = 8'h00;
    step();
    check_out("to_idle", 8'h00, 3'd3, 1'b0, 8'hFF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
